// File: rtl/vital_div_arbiter.sv
// Round-robin arbiter sharing one iterative restoring divider between the HR and SpO2
// requesters: one quotient bit per cycle, one-cycle acknowledge per requester.
module vital_div_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hr_req,
  input  logic [WIDTH-1:0] hr_dividend,
  input  logic [WIDTH-1:0] hr_divisor,
  output logic             hr_ack,
  output logic [WIDTH-1:0] hr_quotient,
  output logic             hr_div_zero,
  input  logic             spo2_req,
  input  logic [WIDTH-1:0] spo2_dividend,
  input  logic [WIDTH-1:0] spo2_divisor,
  output logic             spo2_ack,
  output logic [WIDTH-1:0] spo2_quotient,
  output logic             spo2_div_zero,
  output logic             busy,
  output logic             owner
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dq_sh;      // dividend shifts out of the MSB as quotient bits enter the LSB
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;

  logic             grant_any;
  logic             grant_sel;
  logic [WIDTH-1:0] sel_dividend;
  logic [WIDTH-1:0] sel_divisor;
  logic [WIDTH+1:0] step;
  logic [WIDTH-1:0] final_quotient;

  // One restoring step: returns {quotient bit, next remainder}.
  function automatic logic [WIDTH+1:0] div_step(input logic [WIDTH:0]   r,
                                                input logic             b,
                                                input logic [WIDTH-1:0] d);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;
    logic             ok;
    shifted = {r, b};
    ok      = (shifted >= {2'b00, d});
    diff    = shifted[WIDTH:0] - {1'b0, d};
    div_step = ok ? {1'b1, diff} : {1'b0, shifted[WIDTH:0]};
  endfunction

  always_comb begin
    grant_any = hr_req | spo2_req;
    grant_sel = spo2_req;
    if (hr_req && spo2_req) grant_sel = ~last_grant;
    sel_dividend   = grant_sel ? spo2_dividend : hr_dividend;
    sel_divisor    = grant_sel ? spo2_divisor  : hr_divisor;
    step           = div_step(rem, dq_sh[WIDTH-1], dvs);
    final_quotient = {dq_sh[WIDTH-2:0], step[WIDTH+1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      dq_sh         <= '0;
      dvs           <= '0;
      rem           <= '0;
      cnt           <= '0;
      last_grant    <= 1'b1;
      hr_ack        <= 1'b0;
      hr_quotient   <= '0;
      hr_div_zero   <= 1'b0;
      spo2_ack      <= 1'b0;
      spo2_quotient <= '0;
      spo2_div_zero <= 1'b0;
      busy          <= 1'b0;
      owner         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            owner      <= grant_sel;
            last_grant <= grant_sel;
            busy       <= 1'b1;
            dq_sh      <= sel_dividend;
            dvs        <= sel_divisor;
            rem        <= '0;
            if (sel_divisor == '0) begin
              // Zero divisor skips the iteration and reports saturated quotient.
              cnt   <= '0;
              state <= S_DONE;
              if (grant_sel) begin
                spo2_quotient <= '1;
                spo2_div_zero <= 1'b1;
                spo2_ack      <= 1'b1;
              end else begin
                hr_quotient <= '1;
                hr_div_zero <= 1'b1;
                hr_ack      <= 1'b1;
              end
            end else begin
              cnt   <= CNT_W'(WIDTH);
              state <= S_DIVIDE;
            end
          end
        end

        S_DIVIDE: begin
          rem   <= step[WIDTH:0];
          dq_sh <= final_quotient;
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= S_DONE;
            if (owner) begin
              spo2_quotient <= final_quotient;
              spo2_div_zero <= 1'b0;
              spo2_ack      <= 1'b1;
            end else begin
              hr_quotient <= final_quotient;
              hr_div_zero <= 1'b0;
              hr_ack      <= 1'b1;
            end
          end
        end

        S_DONE: begin
          hr_ack   <= 1'b0;
          spo2_ack <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vital_div_arbiter.sv
// Scoreboard bench for vital_div_arbiter: drivers queue expected results, a negedge monitor checks them.
module tb_vital_div_arbiter;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         hr_req = 1'b0;
  logic [W-1:0] hr_dividend = '0;
  logic [W-1:0] hr_divisor = '0;
  logic         hr_ack;
  logic [W-1:0] hr_quotient;
  logic         hr_div_zero;
  logic         spo2_req = 1'b0;
  logic [W-1:0] spo2_dividend = '0;
  logic [W-1:0] spo2_divisor = '0;
  logic         spo2_ack;
  logic [W-1:0] spo2_quotient;
  logic         spo2_div_zero;
  logic         busy;
  logic         owner;

  int n_vec = 0;
  int n_err = 0;

  exp_t q_hr[$];
  exp_t q_sp[$];

  // Monitor-side model state
  logic         last_g = 1'b1;
  logic         busy_s = 1'b0;
  logic         req_h_s = 1'b0;
  logic         req_s_s = 1'b0;
  int           run = 0;
  logic [W-1:0] hr_mq = '0;
  logic         hr_mdz = 1'b0;
  logic [W-1:0] sp_mq = '0;
  logic         sp_mdz = 1'b0;

  vital_div_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .hr_req(hr_req), .hr_dividend(hr_dividend), .hr_divisor(hr_divisor),
    .hr_ack(hr_ack), .hr_quotient(hr_quotient), .hr_div_zero(hr_div_zero),
    .spo2_req(spo2_req), .spo2_dividend(spo2_dividend), .spo2_divisor(spo2_divisor),
    .spo2_ack(spo2_ack), .spo2_quotient(spo2_quotient), .spo2_div_zero(spo2_div_zero),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q  = {W{1'b1}};
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic check_ack(input bit sel);
    exp_t e;
    if (sel ? (q_sp.size() == 0) : (q_hr.size() == 0)) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_ack sel=%0d: got ack expected none (t=%0t)", sel, $time);
    end else begin
      e = sel ? q_sp.pop_front() : q_hr.pop_front();
      if (sel) begin
        chk("spo2_quotient", spo2_quotient, e.q);
        chk("spo2_div_zero", spo2_div_zero, e.dz);
        sp_mq = e.q; sp_mdz = e.dz;
      end else begin
        chk("hr_quotient", hr_quotient, e.q);
        chk("hr_div_zero", hr_div_zero, e.dz);
        hr_mq = e.q; hr_mdz = e.dz;
      end
      chk("ack_latency", run, e.dz ? 1 : W + 1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_g = 1'b1; busy_s = 1'b0; run = 0;
      hr_mq = '0; hr_mdz = 1'b0; sp_mq = '0; sp_mdz = 1'b0;
      req_h_s = hr_req; req_s_s = spo2_req;
    end else begin
      logic exp_owner;
      chk("single_ack", {63'b0, hr_ack & spo2_ack}, 64'd0);
      if (busy) run++; else run = 0;
      if (busy && !busy_s) begin
        exp_owner = (req_h_s && req_s_s) ? ~last_g : req_s_s;
        chk("owner", owner, exp_owner);
        last_g = exp_owner;
      end
      if (hr_ack) check_ack(1'b0);
      else begin
        chk("hr_hold_q", hr_quotient, hr_mq);
        chk("hr_hold_dz", hr_div_zero, hr_mdz);
      end
      if (spo2_ack) check_ack(1'b1);
      else begin
        chk("spo2_hold_q", spo2_quotient, sp_mq);
        chk("spo2_hold_dz", spo2_div_zero, sp_mdz);
      end
      busy_s = busy; req_h_s = hr_req; req_s_s = spo2_req;
    end
  end

  // Call at #1 after a rising edge; returns at #1 after the edge that raised ack.
  task automatic run_req(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b);
    int  n;
    bit  got;
    n = 0; got = 0;
    if (sel) begin
      spo2_dividend = a; spo2_divisor = b; spo2_req = 1'b1; q_sp.push_back(model(a, b));
    end else begin
      hr_dividend = a; hr_divisor = b; hr_req = 1'b1; q_hr.push_back(model(a, b));
    end
    while (n < 200 && !got) begin
      @(posedge clk); #1;
      n++;
      got = sel ? spo2_ack : hr_ack;
    end
    if (sel) spo2_req = 1'b0; else hr_req = 1'b0;
    if (!got) chk("ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (n < 20 && !busy) begin
      @(posedge clk); #1;
      n++;
    end
    if (!busy) chk("grant_timeout", 64'd0, 64'd1);
  endtask

  task automatic gap(input int c);
    repeat (c + 1) @(posedge clk);
    #1;
  endtask

  task automatic rand_traffic(input bit sel, input int count);
    logic [W-1:0] a, b;
    int r;
    for (int i = 0; i < count; i++) begin
      r = $urandom_range(0, 7);
      a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1000)) : W'($urandom);
      if (r == 0)      b = '0;
      else if (r < 3)  b = W'($urandom_range(1, 255));
      else if (r == 3) b = W'(1);
      else             b = W'($urandom);
      run_req(sel, a, b);
      gap($urandom_range(0, 3));
    end
  endtask

  initial begin
    #1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hr_ack", hr_ack, 0);
    chk("rst_spo2_ack", spo2_ack, 0);
    chk("rst_hr_q", hr_quotient, 0);
    chk("rst_spo2_q", spo2_quotient, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    rst_n = 1'b1;
    gap(1);

    // Tie right after reset: HR first, then SpO2
    fork
      run_req(1'b0, 32'd1000, 32'd7);
      run_req(1'b1, 32'd999, 32'd3);
    join
    gap(1);

    run_req(1'b0, 32'd60_000_000, 32'd750_000);
    chk("hr_80", hr_quotient, 32'd80);
    chk("spo2_untouched", spo2_quotient, 32'd333);
    gap(2);
    run_req(1'b1, 32'd1_234_567, 32'd1000);
    gap(0);
    run_req(1'b1, 32'd5, 32'd9);
    gap(0);
    run_req(1'b1, 32'hFFFF_FFFF, 32'd1);
    gap(1);

    // Divide by zero, then a valid request clears the flag
    run_req(1'b0, 32'd1234, 32'd0);
    gap(0);
    run_req(1'b0, 32'd100, 32'd10);
    chk("hr_dz_cleared", hr_div_zero, 0);
    gap(1);

    // Operand and req perturbation during DIVIDE
    hr_dividend = 32'd500_000; hr_divisor = 32'd123; hr_req = 1'b1;
    q_hr.push_back(model(32'd500_000, 32'd123));
    wait_busy();
    repeat (5) @(posedge clk);
    #1;
    hr_dividend = 32'd7; hr_divisor = 32'd0; hr_req = 1'b0;
    begin
      int n = 0;
      while (n < 60 && !hr_ack) begin @(posedge clk); #1; n++; end
      chk("perturb_ack", hr_ack, 1);
    end
    gap(2);

    // Reset in the middle of an SpO2 division
    spo2_dividend = 32'd77_777; spo2_divisor = 32'd3; spo2_req = 1'b1;
    wait_busy();
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0; spo2_req = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_owner", owner, 0);
    chk("mid_rst_acks", {hr_ack, spo2_ack}, 0);
    chk("mid_rst_hr_q", {hr_quotient, hr_div_zero}, 0);
    chk("mid_rst_spo2_q", {spo2_quotient, spo2_div_zero}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    fork
      run_req(1'b1, 32'd81, 32'd9);
      run_req(1'b0, 32'd90, 32'd9);
    join
    gap(1);

    // Randomized contention; owner checks cover alternation
    fork
      rand_traffic(1'b0, 20);
      rand_traffic(1'b1, 20);
    join
    gap(4);
    chk("hr_queue_drained", q_hr.size(), 0);
    chk("spo2_queue_drained", q_sp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vital_div_arbiter.md
# vital_div_arbiter

Shares one iterative restoring divider between the two vital-sign requesters: the heart-rate path (60·f / interval) and the SpO₂ ratio path (numerator / denominator). The block arbitrates round-robin, captures operands at grant, runs the division one quotient bit per cycle, and returns the quotient with a one-cycle acknowledge. It sits between the HR/SpO₂ calculation logic and their former per-path combinational dividers, which it replaces.

## Interface
- WIDTH, 32, dividend/divisor/quotient width (≥2)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- hr_req  in  1  HR request; level, held with operands stable until hr_ack
- hr_dividend  in  WIDTH  HR dividend
- hr_divisor  in  WIDTH  HR divisor
- hr_ack  out  1  one-cycle pulse: hr_quotient/hr_div_zero valid
- hr_quotient  out  WIDTH  last HR quotient, held until next hr_ack
- hr_div_zero  out  1  last HR request had divisor 0
- spo2_req, spo2_dividend, spo2_divisor, spo2_ack, spo2_quotient, spo2_div_zero: same as HR set, SpO₂ requester
- busy  out  1  high in DIVIDE and DONE
- owner  out  1  current/last grantee: 0 = HR, 1 = SpO₂

## Operation
- States: IDLE, DIVIDE, DONE. Reset: IDLE.
- IDLE: if no req, stay. If exactly one req, grant it. If both, grant the one not equal to last_grant; last_grant resets to SpO₂ so HR wins the first tie.
- Grant edge: latch dividend, divisor, owner; last_grant <= grantee. Divisor ≠ 0 → DIVIDE, bit counter = WIDTH. Divisor = 0 → DONE directly, result quotient = all ones, div_zero = 1.
- DIVIDE: restoring division, MSB-first; remainder register WIDTH+1 bits; per cycle shift {rem, dividend MSB}, subtract divisor if non-negative, shift quotient bit in; counter decrements. On the edge performing the WIDTH-th iteration: write grantee's quotient and div_zero = 0, set grantee's ack, → DONE.
- DONE: one cycle, grantee ack high; next edge ack <= 0, → IDLE.
- Quotient/div_zero outputs of the non-granted requester never change.
- Operands are sampled only at grant; changes to operands or req during DIVIDE/DONE are ignored; a request in flight is never aborted.
- Requester drops req in the cycle ack is high; a req still high when IDLE is re-entered is a new request (and loses a tie per round-robin).
- Integer truncation; quotient exact for any unsigned WIDTH-bit operands; dividend < divisor → quotient 0.

## Timing
- Reset values: hr_ack = spo2_ack = 0, hr_quotient = spo2_quotient = 0, hr_div_zero = spo2_div_zero = 0, busy = 0, owner = 0; internal last_grant = 1, state IDLE, counter/remainder 0.
- Reset asserted mid-operation: immediate return to reset values; no ack is produced for the interrupted request.
- Latency, req sampled at edge E0 (grant): ack high in cycle after edge E_WIDTH (WIDTH+1 edges after grant); IDLE after E_WIDTH+1; earliest next grant E_WIDTH+2. Throughput one division per WIDTH+2 cycles.
- Divisor zero: ack high in cycle after E0; next grant at E2.
- Quotient outputs update on the same edge ack rises; stable ≥ until next ack of that requester.
- busy rises the cycle after grant edge, falls the cycle after DONE.
- Only one ack high in any cycle; never both.

## Test plan
- Single HR: hr_dividend = 60_000_000, hr_divisor = 750_000 → hr_ack one cycle, 33 edges after grant (WIDTH=32); hr_quotient = 80, hr_div_zero = 0; spo2 outputs remain 0.
- Single SpO₂: dividend 1_234_567, divisor 1_000 → spo2_quotient = 1234; dividend 5, divisor 9 → 0; dividend 0xFFFFFFFF, divisor 1 → 0xFFFFFFFF.
- Tie after reset: both req high in same cycle → HR granted first (owner = 0), quotient returned, then SpO₂ granted at next IDLE; both held continuously → grants alternate HR, SpO₂, HR, SpO₂.
- Divide by zero: hr_divisor = 0 → hr_ack 1 cycle after grant, hr_quotient = 0xFFFFFFFF, hr_div_zero = 1; following valid HR request clears hr_div_zero.
- Operand/req perturbation: change hr_dividend and drop hr_req mid-DIVIDE → result equals operands at grant, hr_ack still issued.
- Reset mid-DIVIDE: assert rst_n low 10 cycles after grant → all outputs 0 immediately; after release, no ack until a new request; tie then goes to HR.
